// File: rtl/rect_fill_avalon.sv
// rect_fill_avalon: rectangle-fill engine that sits in front of the 160x120 VGA pixel slave.
// The CPU programs two corners and a colour through the Avalon-MM slave, then starts the fill.
// The Avalon-MM master then issues one plot write per pixel, row-major, to PLOT_ADDR.
//
// Ports
//   clk, reset_n                 system clock, asynchronous active-low reset
//   address/read/readdata        slave: 0=P0 {y[14:8],x[7:0]}, 1=P1, 2=COLOUR[2:0], 3=CTRL/STATUS
//   write/writedata              slave write strobe and data
//   master_address               constant PLOT_ADDR
//   master_write/_writedata      pixel write {13'b0, colour, x, 1'b0, y}
//   master_waitrequest           stall from the VGA slave
//   busy                         fill in progress
//
// state    | meaning
// ST_IDLE  | waiting for a start command
// ST_PLOT  | issuing pixel writes, holding the current beat while stalled
// ST_DONE  | one-cycle completion, sets done_sticky
module rect_fill_avalon #(
   parameter logic [31:0] PLOT_ADDR = 32'h0,
   parameter int          XMAX      = 159,
   parameter int          YMAX      = 119
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        read,
   output logic [31:0] readdata,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] master_address,
   output logic        master_write,
   output logic [31:0] master_writedata,
   input  logic        master_waitrequest,
   output logic        busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_PLOT, ST_DONE} state_t;

   localparam logic [7:0] XMAX_L = 8'(XMAX);
   localparam logic [6:0] YMAX_L = 7'(YMAX);

   state_t      state_q, state_d;
   logic [14:0] p0_q, p0_d, p1_q, p1_d;
   logic [2:0]  colour_q, colour_d, fcol_q, fcol_d;
   logic        done_q, done_d;
   logic [7:0]  xl_q, xl_d, xh_q, xh_d, x_q, x_d;
   logic [6:0]  yl_q, yl_d, yh_q, yh_d, y_q, y_d;

   logic [7:0]  cx0, cx1;
   logic [6:0]  cy0, cy1;
   logic        start;
   logic        unused_wdata;

   assign unused_wdata = ^writedata[31:15];

   // Clamp before ordering so an out-of-range corner can never produce a wrapped address.
   assign cx0 = (p0_q[7:0]  > XMAX_L) ? XMAX_L : p0_q[7:0];
   assign cx1 = (p1_q[7:0]  > XMAX_L) ? XMAX_L : p1_q[7:0];
   assign cy0 = (p0_q[14:8] > YMAX_L) ? YMAX_L : p0_q[14:8];
   assign cy1 = (p1_q[14:8] > YMAX_L) ? YMAX_L : p1_q[14:8];

   assign start = write && (address == 2'd3) && writedata[0] && (state_q == ST_IDLE);

   always_comb begin
      state_d  = state_q;
      p0_d     = p0_q;
      p1_d     = p1_q;
      colour_d = colour_q;
      fcol_d   = fcol_q;
      done_d   = done_q;
      xl_d     = xl_q;
      xh_d     = xh_q;
      yl_d     = yl_q;
      yh_d     = yh_q;
      x_d      = x_q;
      y_d      = y_q;

      if (write) begin
         case (address)
            2'd0:    p0_d     = writedata[14:0];
            2'd1:    p1_d     = writedata[14:0];
            2'd2:    colour_d = writedata[2:0];
            default: done_d   = 1'b0;
         endcase
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               // Latches the pre-write register values, so a same-cycle corner
               // write only affects the next fill.
               xl_d    = (cx0 < cx1) ? cx0 : cx1;
               xh_d    = (cx0 < cx1) ? cx1 : cx0;
               yl_d    = (cy0 < cy1) ? cy0 : cy1;
               yh_d    = (cy0 < cy1) ? cy1 : cy0;
               x_d     = (cx0 < cx1) ? cx0 : cx1;
               y_d     = (cy0 < cy1) ? cy0 : cy1;
               fcol_d  = colour_q;
               state_d = ST_PLOT;
            end
         end
         ST_PLOT: begin
            if (!master_waitrequest) begin
               if (x_q < xh_q) begin
                  x_d = x_q + 8'd1;
               end else if (y_q < yh_q) begin
                  x_d = xl_q;
                  y_d = y_q + 7'd1;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         default: begin
            // Completion wins over a coincident status write so a finish is never lost.
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         p0_q     <= '0;
         p1_q     <= '0;
         colour_q <= '0;
         fcol_q   <= '0;
         done_q   <= 1'b0;
         xl_q     <= '0;
         xh_q     <= '0;
         yl_q     <= '0;
         yh_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
      end else begin
         state_q  <= state_d;
         p0_q     <= p0_d;
         p1_q     <= p1_d;
         colour_q <= colour_d;
         fcol_q   <= fcol_d;
         done_q   <= done_d;
         xl_q     <= xl_d;
         xh_q     <= xh_d;
         yl_q     <= yl_d;
         yh_q     <= yh_d;
         x_q      <= x_d;
         y_q      <= y_d;
      end
   end

   always_comb begin
      readdata = '0;
      if (read) begin
         case (address)
            2'd0:    readdata = {17'b0, p0_q};
            2'd1:    readdata = {17'b0, p1_q};
            2'd2:    readdata = {29'b0, colour_q};
            default: readdata = {30'b0, done_q, busy};
         endcase
      end
   end

   assign busy             = (state_q != ST_IDLE);
   assign master_address   = PLOT_ADDR;
   assign master_write     = (state_q == ST_PLOT);
   assign master_writedata = {13'b0, fcol_q, x_q, 1'b0, y_q};

endmodule

// File: tb/tb_rect_fill_avalon.sv
module tb_rect_fill_avalon;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        read = 1'b0;
   logic [31:0] readdata;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] master_address;
   logic        master_write;
   logic [31:0] master_writedata;
   logic        master_waitrequest = 1'b0;
   logic        busy;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] beats[$];
   logic [31:0] exp_q[$];
   int          stall_checks = 0;
   int          stall_viol = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        rand_en = 1'b0;

   rect_fill_avalon dut (
      .clk(clk), .reset_n(reset_n),
      .address(address), .read(read), .readdata(readdata),
      .write(write), .writedata(writedata),
      .master_address(master_address), .master_write(master_write),
      .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      master_waitrequest = rand_en ? 1'($urandom_range(1, 0)) : 1'b0;
   end

   // Bus monitor: accepted beats and hold-stability while stalled.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            stall_checks++;
            if (!(master_write === 1'b1 && master_writedata === prev_data)) stall_viol++;
         end
         if (master_write && !master_waitrequest) beats.push_back(master_writedata);
         prev_stall = master_write && master_waitrequest;
         prev_data  = master_writedata;
      end
   end

   function automatic logic [31:0] px(input int c, input int x, input int y);
      return {13'b0, 3'(c), 8'(x), 1'b0, 7'(y)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      address = a; writedata = d; write = 1'b1;
      @(posedge clk); #1;
      write = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] expv);
      address = a; read = 1'b1;
      #1;
      chk(tag, readdata, expv);
      read = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (busy && n < max_cyc) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", {31'b0, busy}, 32'h0);
   endtask

   task automatic check_seq(input string tag, input int base);
      chk({tag, "_count"}, 32'(beats.size() - base), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (base + i < beats.size()) chk({tag, "_beat"}, beats[base + i], exp_q[i]);
      end
   endtask

   task automatic exp_rect(input int c, input int x0, input int y0, input int x1, input int y1);
      exp_q.delete();
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            exp_q.push_back(px(c, x, y));
   endtask

   initial begin
      int base;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_master_write", {31'b0, master_write}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_master_address", master_address, 32'h0);
      rd_chk("rst_status", 2'd3, 32'h0);
      reset_n = 1'b1;
      rd_chk("rst_p0", 2'd0, 32'h0);

      // 3x2 fill, including busy timing
      wr(2'd0, 32'h0000_050A);
      wr(2'd1, 32'h0000_060C);
      wr(2'd2, 32'h0000_0003);
      rd_chk("rd_p1", 2'd1, 32'h0000_060C);
      rd_chk("rd_colour", 2'd2, 32'h3);
      exp_q = '{32'h0003_0A05, 32'h0003_0B05, 32'h0003_0C05,
                32'h0003_0A06, 32'h0003_0B06, 32'h0003_0C06};
      base = beats.size();
      wr(2'd3, 32'h1);
      chk("busy_after_start", {31'b0, busy}, 32'h1);
      repeat (6) @(posedge clk);
      #1;
      chk("busy_in_done", {31'b0, busy}, 32'h1);
      chk("no_write_in_done", {31'b0, master_write}, 32'h0);
      @(posedge clk); #1;
      chk("busy_low", {31'b0, busy}, 32'h0);
      check_seq("fill_3x2", base);
      rd_chk("done_sticky", 2'd3, 32'h2);

      // Swapped corners
      wr(2'd0, 32'h0000_060C);
      wr(2'd1, 32'h0000_050A);
      base = beats.size();
      wr(2'd3, 32'h1);
      rd_chk("status_busy", 2'd3, 32'h1);
      wait_idle(50);
      check_seq("swapped", base);

      // Degenerate single pixel
      wr(2'd0, 32'h0);
      wr(2'd1, 32'h0);
      wr(2'd2, 32'h0);
      exp_q = '{32'h0000_0000};
      base = beats.size();
      wr(2'd3, 32'h1);
      wait_idle(50);
      check_seq("single", base);
      rd_chk("single_done", 2'd3, 32'h2);
      wr(2'd3, 32'h0);
      rd_chk("done_clear", 2'd3, 32'h0);

      // Clamping
      wr(2'd1, 32'h0000_7FC8);
      wr(2'd0, 32'h0000_769E);
      wr(2'd2, 32'h7);
      exp_q = '{32'h0007_9E76, 32'h0007_9F76, 32'h0007_9E77, 32'h0007_9F77};
      base = beats.size();
      wr(2'd3, 32'h1);
      wait_idle(50);
      check_seq("clamp", base);

      // Random stalls on a 3x3 fill
      wr(2'd0, 32'h0000_0201);
      wr(2'd1, 32'h0000_0403);
      wr(2'd2, 32'h5);
      exp_rect(5, 1, 2, 3, 4);
      base = beats.size();
      rand_en = 1'b1;
      wr(2'd3, 32'h1);
      wait_idle(400);
      rand_en = 1'b0;
      @(posedge clk); #1;
      check_seq("stall", base);
      chk("stall_seen", {31'b0, stall_checks > 0}, 32'h1);
      chk("stall_stable", 32'(stall_viol), 32'h0);

      // Start and corner writes while busy are ignored by the running fill
      base = beats.size();
      wr(2'd3, 32'h1);
      wr(2'd3, 32'h1);
      wr(2'd0, 32'h0000_0000);
      wr(2'd3, 32'h1);
      wait_idle(50);
      check_seq("start_busy", base);
      wr(2'd0, 32'h0000_0201);

      // Reset mid-fill, then a full restart
      wr(2'd3, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_write", {31'b0, master_write}, 32'h0);
      chk("rst_mid_busy", {31'b0, busy}, 32'h0);
      rd_chk("rst_mid_p0", 2'd0, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("no_resume", {31'b0, busy}, 32'h0);
      wr(2'd0, 32'h0000_0201);
      wr(2'd1, 32'h0000_0403);
      wr(2'd2, 32'h5);
      base = beats.size();
      wr(2'd3, 32'h1);
      wait_idle(50);
      check_seq("restart", base);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
